// File: rtl/fm_modulator.sv
// rtl/fm_modulator.sv - digital FM transmitter: 2-entry audio FIFO feeding a DDS with 1-bit output
//
// Purpose:
//   Audio samples arrive on a valid/ready handshake and wait in a 2-entry FIFO.
//   One sample is consumed per 32 kHz audio enable. It is scaled by the deviation
//   gain and added to the carrier constant K to form the DDS phase increment.
//   The MSB of the phase accumulator is the 1-bit broadcast signal.
//
// Ports:
//   clk          sampling clock
//   reset        asynchronous active-low reset
//   en_a         audio-rate enable, one clk wide
//   enable       transmitter on; low returns to idle and flushes everything
//   K            carrier phase increment constant
//   kdev         unsigned deviation gain
//   audio        signed audio sample
//   audio_valid  source presents a sample
//   audio_ready  FIFO can accept a sample (registered)
//   tx           1-bit modulated output (phase MSB)
//   underrun     sticky: a sample was needed in RUN while the FIFO was empty
//   inc_mon      registered phase increment currently applied to the accumulator

module fm_modulator #(
    parameter int width_dds   = 32,
    parameter int width_audio = 16,
    parameter int width_kdev  = 16,
    parameter int SHIFT       = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en_a,
    input  logic                          enable,
    input  logic [width_dds-1:0]          K,
    input  logic [width_kdev-1:0]         kdev,
    input  logic signed [width_audio-1:0] audio,
    input  logic                          audio_valid,
    output logic                          audio_ready,
    output logic                          tx,
    output logic                          underrun,
    output logic [width_dds-1:0]          inc_mon
);

    // Signed audio times kdev widened by a zero sign bit: full-precision product.
    localparam int width_prod = width_audio + width_kdev + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t state, state_nxt;

    // FIFO storage and bookkeeping
    logic signed [width_audio-1:0] fifo_mem [2];
    logic                          wr_ptr;
    logic                          rd_ptr;
    logic [1:0]                    count;
    logic [1:0]                    count_nxt;

    logic push;
    logic pop;
    logic starve;
    logic active;
    logic fifo_empty;

    // Datapath
    logic signed [width_audio-1:0] sample;
    logic signed [width_prod-1:0]  sample_ext;
    logic signed [width_prod-1:0]  kdev_ext;
    logic signed [width_prod-1:0]  prod;
    logic signed [width_prod-1:0]  prod_shift;
    logic [width_dds-1:0]          phase;

    assign active     = (state != IDLE);
    assign fifo_empty = (count == 2'd0);
    assign push       = audio_valid && audio_ready && enable;
    // Pop looks at occupancy before any same-cycle push, so a sample pushed
    // into an empty FIFO waits for the next audio enable.
    assign pop        = enable && active && en_a && !fifo_empty;
    assign starve     = enable && (state == RUN) && en_a && fifo_empty;

    assign sample_ext = width_prod'(sample);
    assign kdev_ext   = $signed(width_prod'(kdev));
    assign prod_shift = prod >>> SHIFT;

    assign tx = phase[width_dds-1];

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (!enable) begin
            state_nxt = IDLE;
            count_nxt = 2'd0;
        end else begin
            case (state)
                IDLE:    state_nxt = PRIME;
                PRIME:   if (pop) state_nxt = RUN;
                RUN:     state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
            case ({push, pop})
                2'b10:   count_nxt = count + 2'd1;
                2'b01:   count_nxt = count - 2'd1;
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FIFO; audio_ready follows the occupancy we are about to have, so it
    // drops in the cycle right after the FIFO fills and a third push is refused.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            audio_ready <= 1'b0;
        end else if (!enable) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            audio_ready <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= audio;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count       <= count_nxt;
            audio_ready <= (count_nxt != 2'd2);
        end
    end

    // Sample register and sticky underrun flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample   <= '0;
            underrun <= 1'b0;
        end else if (!enable) begin
            sample   <= '0;
            underrun <= 1'b0;
        end else begin
            if (pop) begin
                sample <= fifo_mem[rd_ptr];
            end
            if (starve) begin
                underrun <= 1'b1;
            end
        end
    end

    // Increment pipeline runs every clock, so K and kdev changes propagate
    // even while idle; phase only advances while transmitting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod    <= '0;
            inc_mon <= '0;
            phase   <= '0;
        end else begin
            prod    <= sample_ext * kdev_ext;
            inc_mon <= K + width_dds'(prod_shift);
            if (!enable || state == IDLE) begin
                phase <= '0;
            end else begin
                phase <= phase + inc_mon;
            end
        end
    end

endmodule

// File: tb/tb_fm_modulator.sv
// tb/tb_fm_modulator.sv - self-checking bench for fm_modulator with a behavioural reference model

module tb_fm_modulator;

    logic               clk = 1'b0;
    logic               reset;
    logic               en_a;
    logic               enable;
    logic [31:0]        K;
    logic [15:0]        kdev;
    logic signed [15:0] audio;
    logic               audio_valid;
    logic               audio_ready;
    logic               tx;
    logic               underrun;
    logic [31:0]        inc_mon;

    always #5 clk = ~clk;

    fm_modulator #(
        .width_dds   (32),
        .width_audio (16),
        .width_kdev  (16),
        .SHIFT       (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en_a        (en_a),
        .enable      (enable),
        .K           (K),
        .kdev        (kdev),
        .audio       (audio),
        .audio_valid (audio_valid),
        .audio_ready (audio_ready),
        .tx          (tx),
        .underrun    (underrun),
        .inc_mon     (inc_mon)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: queue of pending samples, operating mode
    // (0 idle, 1 priming, 2 running), current sample and the values
    // expected on the outputs after each edge.
    int          mq[$];
    int          m_state;
    int          m_sample;
    longint      m_prod;
    logic [31:0] m_inc;
    logic [31:0] m_phase;
    logic        m_underrun;
    logic        m_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_state    = 0;
        m_sample   = 0;
        m_prod     = 0;
        m_inc      = 32'd0;
        m_phase    = 32'd0;
        m_underrun = 1'b0;
        m_ready    = 1'b0;
    endtask

    // One clock edge: increment = K + floor(sample*kdev / 256), with the product
    // taken one cycle after the sample is visible and K one cycle later.
    task automatic model_edge();
        logic [31:0] n_inc;
        longint      n_prod;
        logic [31:0] n_phase;
        bit          push;
        push    = audio_valid && m_ready;
        n_inc   = K + 32'(m_prod >>> 8);
        n_prod  = longint'(m_sample) * longint'(kdev);
        n_phase = (!enable || m_state == 0) ? 32'd0 : m_phase + m_inc;
        if (!enable) begin
            mq.delete();
            m_state    = 0;
            m_sample   = 0;
            m_underrun = 1'b0;
        end else begin
            if (en_a && m_state != 0) begin
                if (mq.size() > 0) begin
                    m_sample = mq.pop_front();
                    m_state  = 2;
                end else if (m_state == 2) begin
                    m_underrun = 1'b1;
                end
            end
            if (m_state == 0) m_state = 1;
            if (push) mq.push_back(int'(audio));
        end
        m_ready = enable && (mq.size() < 2);
        m_inc   = n_inc;
        m_prod  = n_prod;
        m_phase = n_phase;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        #1;
        check("tx", tx, m_phase[31]);
        check("inc_mon", inc_mon, m_inc);
        check("underrun", underrun, m_underrun);
        check("audio_ready", audio_ready, m_ready);
    endtask

    initial begin
        int   tg;
        logic prev;
        logic exp_tx;

        reset       = 1'b0;
        en_a        = 1'b0;
        enable      = 1'b0;
        audio_valid = 1'b0;
        audio       = '0;
        K           = 32'd0;
        kdev        = 16'd0;
        model_reset();

        // Reset state
        repeat (3) tick();
        check("rst_inc", inc_mon, 32'd0);
        check("rst_tx", tx, 1'b0);
        check("rst_ready", audio_ready, 1'b0);

        // Unmodulated carrier in PRIME
        reset  = 1'b1;
        enable = 1'b1;
        K      = 32'h6AAAAAAB;
        kdev   = 16'd10486;
        repeat (4) tick();
        check("prime_inc", inc_mon, 32'h6AAAAAAB);
        check("prime_ready", audio_ready, 1'b1);
        check("prime_underrun", underrun, 1'b0);
        tg   = 0;
        prev = tx;
        repeat (20) begin
            tick();
            if (tx !== prev) tg++;
            prev = tx;
        end
        check("prime_tx_toggles", (tg > 0), 1'b1);

        // Full-scale positive sample, 3-cycle latency into inc_mon
        audio = 16'sd32767; audio_valid = 1'b1; tick();
        audio_valid = 1'b0; tick();
        en_a = 1'b1; tick(); en_a = 1'b0;
        tick();
        check("lat_before", inc_mon, 32'h6AAAAAAB);
        tick();
        check("pos_full", inc_mon, 32'h6AAAAAAB + 32'd1342167);

        // Full-scale negative sample
        audio = -16'sd32768; audio_valid = 1'b1; tick();
        audio_valid = 1'b0; tick();
        en_a = 1'b1; tick(); en_a = 1'b0;
        repeat (2) tick();
        check("neg_full", inc_mon, 32'h6AAAAAAB - 32'd1342208);

        // Fill FIFO; third sample must be refused
        audio = 16'sd1000;  audio_valid = 1'b1; tick();
        audio = -16'sd2000; tick();
        check("full_ready", audio_ready, 1'b0);
        audio = 16'sd3000; repeat (2) tick();
        check("full_hold", audio_ready, 1'b0);
        audio_valid = 1'b0;
        en_a = 1'b1; tick(); en_a = 1'b0;
        check("ready_back", audio_ready, 1'b1);
        repeat (2) tick();
        check("pop_first", inc_mon, 32'h6AAAAAAB + 32'd40960);
        en_a = 1'b1; tick(); en_a = 1'b0;
        repeat (2) tick();
        check("pop_second", inc_mon, 32'h6AAAAAAB - 32'd81922);

        // Underrun holds last sample
        en_a = 1'b1; tick(); en_a = 1'b0;
        check("underrun_set", underrun, 1'b1);
        repeat (3) tick();
        check("underrun_hold", inc_mon, 32'h6AAAAAAB - 32'd81922);

        // Disable: idle, flush, clear underrun
        enable = 1'b0; tick();
        check("off_underrun", underrun, 1'b0);
        check("off_tx", tx, 1'b0);
        check("off_ready", audio_ready, 1'b0);
        enable = 1'b1; repeat (3) tick();
        en_a = 1'b1; tick(); en_a = 1'b0;
        repeat (3) tick();
        check("flushed_inc", inc_mon, 32'h6AAAAAAB);

        // Half-rate carrier: tx alternates every clock
        enable = 1'b0; tick();
        enable = 1'b1; K = 32'h80000000;
        repeat (4) tick();
        prev = tx;
        repeat (10) begin
            tick();
            exp_tx = ~prev;
            check("alt_tx", tx, exp_tx);
            prev = tx;
        end

        // K = all ones: phase steps back by one, wraps once to all ones
        enable = 1'b0; tick();
        tg   = 0;
        prev = tx;
        enable = 1'b1; K = 32'hFFFFFFFF;
        repeat (1000) begin
            tick();
            if (tx !== prev) tg++;
            prev = tx;
        end
        check("wrap_toggles", tg, 32'd1);

        // Randomized traffic against the model
        K    = 32'h6AAAAAAB;
        kdev = 16'd10486;
        for (int i = 0; i < 1600; i++) begin
            en_a        = (i % 9 == 0);
            audio_valid = (i < 800) ? ($urandom % 2 == 0) : ($urandom % 16 == 0);
            audio       = 16'($urandom);
            if ($urandom % 100 == 0) kdev = 16'($urandom);
            if ($urandom % 150 == 0) K = $urandom;
            enable      = ($urandom % 300 != 0);
            tick();
        end
        en_a = 1'b0; audio_valid = 1'b0; enable = 1'b1;

        // Asynchronous reset in the middle of RUN
        K = 32'h6AAAAAAB;
        audio = 16'sd1234; audio_valid = 1'b1; tick();
        audio_valid = 1'b0;
        en_a = 1'b1; tick(); en_a = 1'b0;
        repeat (5) tick();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async_inc", inc_mon, 32'd0);
        check("async_tx", tx, 1'b0);
        check("async_underrun", underrun, 1'b0);
        check("async_ready", audio_ready, 1'b0);
        tick();
        reset = 1'b1;
        repeat (6) tick();
        check("after_rst_inc", inc_mon, 32'h6AAAAAAB);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
